// File: rtl/goertzel_pkg.sv
// Shared types and helpers for the single-bin Goertzel power stage.
package goertzel_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, P1, P2, P3, OUT} gz_state_t;

  localparam int DEF_N     = 205;
  localparam int DEF_CW    = 18;
  localparam int DEF_FBITS = 14;

  // Clamp a signed value into the range of a width-bit signed word.
  function automatic logic signed [127:0] sat_signed(input logic signed [127:0] value,
                                                     input int unsigned width);
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< (width - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/goertzel_power_if.sv
// Sample-in / power-out handshake bundle for goertzel_power.
interface goertzel_power_if #(
  parameter int IW    = 16,
  parameter int WIDTH = 32
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_sample;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_power;
  logic                 out_sat;

  modport master (output in_valid, in_sample, out_ready,
                  input  in_ready, out_valid, out_power, out_sat);
  modport slave  (input  in_valid, in_sample, out_ready,
                  output in_ready, out_valid, out_power, out_sat);
endinterface

// File: rtl/goertzel_mulsh.sv
// Full-width signed multiply followed by an arithmetic right shift.
module goertzel_mulsh #(
  parameter int AW    = 18,
  parameter int BW    = 20,
  parameter int SHIFT = 0
) (
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [AW+BW-1:0] p
);
  logic signed [AW+BW-1:0] full;

  assign full = (AW+BW)'(a) * (AW+BW)'(b);
  assign p    = full >>> SHIFT;
endmodule

// File: rtl/goertzel_power.sv
// Goertzel recursion over N samples, then |X|^2 = s1^2 + s2^2 - c*s1*s2.
// Optional build macro GOERTZEL_PWR_SAT_EN: saturate recursion and power, report out_sat.
module goertzel_power
  import goertzel_pkg::*;
#(
  parameter int IW     = 16,
  parameter int CW     = DEF_CW,
  parameter int FBITS  = DEF_FBITS,
  parameter int N      = DEF_N,
  parameter int SW     = IW + $clog2(N) + 2,
  parameter int WIDTH  = 32,
  parameter int PSHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic signed [CW-1:0] coeff,
  goertzel_power_if.slave      bus
);
  localparam int TW   = CW + SW;
  localparam int RW   = TW + 1;
  localparam int PW   = TW + SW;
  localparam int ACCW = 2*SW + 2;
  localparam int CNTW = $clog2(N + 1);
  localparam int PXW  = ((ACCW > WIDTH) ? ACCW : WIDTH) + 1;

  gz_state_t              state_q, state_d;
  logic signed [SW-1:0]   s1_q, s1_d, s2_q, s2_d, s_new;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic signed [CW-1:0]   coeff_q, coeff_d, coeff_sel;
  logic signed [ACCW-1:0] acc_q, acc_d, prod_acc;
  logic                   fin_q, fin_d;
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_power_q, out_power_d, pw;
  logic signed [TW-1:0]   term, mul_a;
  logic signed [SW-1:0]   mul_b;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   s_full;
  logic [ACCW-1:0]        acc_pos, p_sh;
  logic [PXW-1:0]         p_ext;
  logic                   accept;

  // The first sample of a block sees the live coefficient; s1 is zero then anyway.
  assign coeff_sel = (state_q == IDLE) ? coeff : coeff_q;

  goertzel_mulsh #(.AW(CW), .BW(SW), .SHIFT(FBITS)) u_term (
    .a(coeff_sel), .b(s1_q), .p(term)
  );
  goertzel_mulsh #(.AW(TW), .BW(SW), .SHIFT(0)) u_pwr (
    .a(mul_a), .b(mul_b), .p(prod)
  );

  assign accept   = bus.in_valid && in_ready_q;
  assign s_full   = RW'(bus.in_sample) + RW'(term) - RW'(s2_q);
  assign prod_acc = ACCW'(prod);

  // Negative power is only rounding residue of the cross term.
  assign acc_pos = acc_q[ACCW-1] ? '0 : $unsigned(acc_q);
  assign p_sh    = acc_pos >> PSHIFT;
  assign p_ext   = PXW'(p_sh);

`ifdef GOERTZEL_PWR_SAT_EN
  logic signed [127:0] s_wide, s_clip;
  logic                rec_ovf, pow_ovf;
  logic                sat_q, sat_d, out_sat_q, out_sat_d;

  assign s_wide  = 128'(s_full);
  assign s_clip  = sat_signed(s_wide, SW);
  assign s_new   = SW'(s_clip);
  assign rec_ovf = (s_clip != s_wide);
  assign pow_ovf = |(p_ext >> WIDTH);
  assign pw      = pow_ovf ? '1 : WIDTH'(p_ext);
  assign bus.out_sat = out_sat_q;
`else
  assign s_new = SW'(s_full);
  assign pw    = WIDTH'(p_ext);
  assign bus.out_sat = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    cnt_d       = cnt_q;
    coeff_d     = coeff_q;
    acc_d       = acc_q;
    fin_d       = fin_q;
    out_power_d = out_power_q;
    mul_a       = TW'(s1_q);
    mul_b       = s1_q;
`ifdef GOERTZEL_PWR_SAT_EN
    sat_d       = sat_q;
    out_sat_d   = out_sat_q;
`endif
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          s2_d  = s1_q;
          s1_d  = s_new;
          cnt_d = cnt_q + CNTW'(1);
`ifdef GOERTZEL_PWR_SAT_EN
          sat_d = sat_q | rec_ovf;
`endif
          if (state_q == IDLE) coeff_d = coeff;
          state_d = (cnt_q == CNTW'(N - 1)) ? P1 : ACCUM;
        end
      end
      P1: begin
        acc_d   = prod_acc;
        state_d = P2;
      end
      P2: begin
        mul_a   = TW'(s2_q);
        mul_b   = s2_q;
        acc_d   = acc_q + prod_acc;
        state_d = P3;
      end
      P3: begin
        // Two cycles: subtract the cross term, then clamp/shift/register.
        if (!fin_q) begin
          mul_a = term;
          mul_b = s2_q;
          acc_d = acc_q - prod_acc;
          fin_d = 1'b1;
        end else begin
          fin_d       = 1'b0;
          out_power_d = pw;
`ifdef GOERTZEL_PWR_SAT_EN
          out_sat_d   = sat_q | pow_ovf;
`endif
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = '0;
`ifdef GOERTZEL_PWR_SAT_EN
          sat_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d = IDLE;
      s1_d    = '0;
      s2_d    = '0;
      cnt_d   = '0;
      fin_d   = 1'b0;
`ifdef GOERTZEL_PWR_SAT_EN
      sat_d   = 1'b0;
`endif
    end

    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_q        <= '0;
      s2_q        <= '0;
      cnt_q       <= '0;
      coeff_q     <= '0;
      acc_q       <= '0;
      fin_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_power_q <= '0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      coeff_q     <= coeff_d;
      acc_q       <= acc_d;
      fin_q       <= fin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_power_q <= out_power_d;
    end
  end

`ifdef GOERTZEL_PWR_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_power = out_power_q;

endmodule

// File: tb/tb_goertzel_power.sv
// Scoreboard bench for goertzel_power (N=4, WIDTH=24); expectations follow GOERTZEL_PWR_SAT_EN.
module tb_goertzel_power;
  localparam int IW = 16, CW = 18, FBITS = 14, N = 4, WIDTH = 24, SW = IW + 2 + 2;

  typedef struct { longint power; longint sat; } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr;
  logic signed [CW-1:0] coeff;
  exp_t                 sb[$];
  int                   n_chk = 0;
  int                   n_fail = 0;

  goertzel_power_if #(.IW(IW), .WIDTH(WIDTH)) bus ();

  goertzel_power #(
    .IW(IW), .CW(CW), .FBITS(FBITS), .N(N), .WIDTH(WIDTH), .PSHIFT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .coeff(coeff), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input longint p, input longint s);
    exp_t e;
    e.power = p;
    e.sat   = s;
    sb.push_back(e);
  endtask

  // Reference: integer Goertzel over one block, with the configured overflow behaviour.
  task automatic push_model(input int c, input int xs[4]);
    longint s1 = 0, s2 = 0, s, t, p, sat = 0;
    longint hi = (64'sd1 <<< (SW - 1)) - 1;
    longint pmax = (64'sd1 <<< WIDTH) - 1;
    for (int i = 0; i < N; i++) begin
      t = (longint'(c) * s1) >>> FBITS;
      s = longint'(xs[i]) + t - s2;
`ifdef GOERTZEL_PWR_SAT_EN
      if (s > hi) begin s = hi; sat = 1; end
      if (s < -hi - 1) begin s = -hi - 1; sat = 1; end
`else
      s = (s <<< (64 - SW)) >>> (64 - SW);
`endif
      s2 = s1;
      s1 = s;
    end
    p = s1 * s1 + s2 * s2 - ((longint'(c) * s1) >>> FBITS) * s2;
    if (p < 0) p = 0;
`ifdef GOERTZEL_PWR_SAT_EN
    if (p > pmax) begin p = pmax; sat = 1; end
`else
    p = p & pmax;
`endif
    push_exp(p, sat);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 64) chk("ready_timeout", bus.in_ready, 1);
  endtask

  task automatic drive_sample(input int c, input int x);
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'(x);
    coeff         = 18'(c);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic drive_block(input int c, input int xs[4]);
    for (int i = 0; i < N; i++) drive_sample(c, xs[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_power"}, bus.out_power, 0);
    chk({tag, "_out_sat"}, bus.out_sat, 0);
  endtask

  // Pop and compare on the cycle the power word is accepted.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("sb_occupancy", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("power", bus.out_power, e.power);
        chk("sat", bus.out_sat, e.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; coeff = '0;
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Tone with latency and backpressure
    push_exp(40000, 0);
    drive_block(0, '{100, 0, -100, 0});
    chk("in_ready_fall", bus.in_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_edge%0d", k), bus.out_valid, (k == 4) ? 1 : 0);
    end
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_power", bus.out_power, 40000);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hs_valid", bus.out_valid, 0);
    chk("hs_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;

    // DC rejection
    push_exp(0, 0);
    drive_block(0, '{100, 100, 100, 100});
    drain();

    // Saturation / wrap
`ifdef GOERTZEL_PWR_SAT_EN
    push_exp(64'hFFFFFF, 1);
`else
    push_exp(64'hFE0001, 0);
`endif
    drive_block(0, '{32767, 0, -32768, 0});
    drain();

    // Reset mid-block discards the partial block
    drive_sample(0, 100);
    drive_sample(0, 0);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(40000, 0);
    drive_block(0, '{100, 0, -100, 0});
    drain();

    // Abort: the sample presented with clr is dropped
    drive_sample(0, 500);
    drive_sample(0, -300);
    drive_sample(0, 700);
    bus.in_valid = 1'b1; bus.in_sample = 16'sd1234; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; bus.in_valid = 1'b0;
    chk("clr_in_ready", bus.in_ready, 1);
    chk("clr_out_valid", bus.out_valid, 0);
    push_exp(40000, 0);
    drive_block(0, '{100, 0, -100, 0});
    drain();

    // Random coefficients and samples, back to back
    for (int b = 0; b < 8; b++) begin
      int c;
      int xs[4];
      c = int'($urandom_range(0, 65534)) - 32767;
      for (int i = 0; i < 4; i++) xs[i] = int'($urandom_range(0, 4000)) - 2000;
      push_model(c, xs);
      drive_block(c, xs);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/goertzel_power.md
# goertzel_power

Single-bin Goertzel power stage: accepts a stream of signed samples, runs the second-order Goertzel recursion over a block of N samples, then computes the unsigned bin power. The unsigned power word feeds the dividend input of the downstream unsigned fixed-point divider, which performs power normalisation. Glue logic is `start = out_valid && !busy` and `out_ready = start`.

## Interface
- `IW`, 16: input sample width, signed two's complement.
- `CW`, 18: coefficient width, signed, FBITS fractional bits.
- `FBITS`, 14: coefficient fractional bits.
- `N`, 205: samples per block, ≥2.
- `SW`, `IW+$clog2(N)+2`: recursion state width, signed.
- `WIDTH`, 32: output power width. Matches the divider WIDTH.
- `PSHIFT`, 0: right shift applied to the full-precision power before output.

Ports (clock and reset first):
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous abort of the current block. Overrides all other inputs except reset.
- `coeff` in CW: 2·cos(2πk/N), signed Q(CW-FBITS).FBITS. Latched on the first sample of each block.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: stage accepts a sample.
- `in_sample` in IW: signed sample.
- `out_valid` out 1: power word valid. Held until accepted.
- `out_ready` in 1: downstream accepts the power word.
- `out_power` out WIDTH: unsigned bin power.
- `out_sat` out 1: saturation occurred during this block. Valid with `out_valid`.

## Operation
- States: IDLE, ACCUM, P1, P2, P3, OUT.
- IDLE/ACCUM:
  - `in_ready`=1. A sample is accepted when `in_valid && in_ready`.
  - On accept, compute s = x + ((coeff·s1) >>> FBITS) − s2, then update s2←s1, s1←s, cnt←cnt+1.
  - The first accept in IDLE latches `coeff` and moves to ACCUM.
  - The accept that makes cnt==N moves to P1.
- P1: acc ← s1².
- P2: acc ← acc + s2².
- P3: acc ← acc − ((coeff·s1) >>> FBITS)·s2. One shared multiplier serves P1–P3.
- After P3:
  - Negative acc clamps to 0. This is rounding residue; `out_sat` is not set.
  - Then apply the shift: p = acc >> PSHIFT.
  - If p > 2^WIDTH−1, saturate (see Configuration).
  - Register the result to `out_power` and move to OUT.
- OUT:
  - `out_valid`=1, `in_ready`=0. `out_power` and `out_sat` stay stable.
  - On `out_ready`, clear s1, s2, cnt and the sat flag, then return to IDLE.
- Widths:
  - The s1/s2 recursion is SW bits wide.
  - Products are full width, i.e. 2·SW+CW for the P3 term.
  - The accumulator is 2·SW+2 bits, signed.
- `clr`: next state is IDLE; s1, s2, cnt, sat and `out_valid` are cleared. An accept in the same cycle is discarded.
- Reset mid-operation discards the block. No partial result is emitted.

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n` is low, 1 on the first edge after release.
  - `out_valid`=0, `out_power`=0, `out_sat`=0.
  - State IDLE; s1=s2=cnt=0.
- Throughput in ACCUM: one sample per cycle.
- Latency: `out_valid` rises on the 4th rising edge after the edge that accepted sample N.
- `in_ready` falls on the edge that accepts sample N.
- Handshake: the edge with `out_valid && out_ready` drops `out_valid`. `in_ready` is 1 on the next cycle.
- Minimum block period: N+4 cycles, plus one handshake cycle.

## Configuration
- `GOERTZEL_PWR_SAT_EN` defined:
  - The recursion saturates s to the SW-bit range.
  - The power saturates to 2^WIDTH−1.
  - Either event sets the block's `out_sat`.
- Undefined:
  - The recursion and the output wrap (truncate to the low bits).
  - `out_sat` is tied to 0.

## Structure
- Package `goertzel_pkg`:
  - State enum `gz_state_t`.
  - Default N, CW and FBITS localparams.
  - Function `sat_signed(value, width)`.
- One sub-module, `goertzel_mulsh`: signed multiply with optional arithmetic right shift by FBITS. It is used for the recursion term and as the shared P1–P3 multiplier (two instances).

## Test plan
- Tone: N=4, coeff=0, PSHIFT=0. Samples 100, 0, −100, 0 → `out_power`=40000, `out_sat`=0. `out_valid` rises 4 edges after the 4th accept.
- DC rejection: N=4, coeff=0. Samples 100, 100, 100, 100 → `out_power`=0.
- Backpressure: after the tone block, hold `out_ready`=0 for 10 cycles → `out_valid` stays high, `out_power` stays at 40000, `in_ready` stays 0. Pulsing `out_ready` for one cycle returns `in_ready` to 1 on the next cycle.
- Saturation: WIDTH=24, IW=16, N=4, coeff=0. Samples 32767, 0, −32768, 0.
  - With the macro → `out_power`=0xFFFFFF, `out_sat`=1.
  - Without the macro → `out_power`=0xFE0001, `out_sat`=0.
- Reset mid-block: accept 2 samples, pulse `rst_n` low → all outputs at reset values. The tone block that follows → 40000.
- Abort: accept 3 samples, assert `clr` together with `in_valid` → that sample is discarded. The tone block that follows → 40000.
